// File: rtl/fib_pkg.sv
// Shared types and constants for the Fibonacci register-file sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package fib_pkg;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;

    // First register index the sequencer writes; indices 0 and 1 are the seeds.
    localparam logic [ADDR_W-1:0] FIRST_IDX = ADDR_W'(2);

    typedef enum logic [2:0] {
        IDLE,
        READ,
        EXEC,
        WRITE,
        DONE
    } state_t;

endpackage

// File: rtl/fib_add.sv
// Adder for the sequencer: 33-bit sum of two operands, plus result shaping of a held sum.
// Latency: combinational on both paths.
// Backpressure: none; FIB_SAT_EN selects saturation on carry-out, otherwise the result wraps.
module fib_add
    import fib_pkg::*;
(
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W:0]   sum,
    input  logic [DATA_W:0]   sum_reg,
    output logic [DATA_W-1:0] result
);

    // Full-width add keeps the carry-out so overflow can be reported.
    always_comb begin
        sum = {1'b0, a} + {1'b0, b};
    end

    // Shape the captured sum into the value written back to the register file.
    always_comb begin
`ifdef FIB_SAT_EN
        result = sum_reg[DATA_W] ? {DATA_W{1'b1}} : sum_reg[DATA_W-1:0];
`else
        result = sum_reg[DATA_W-1:0];
`endif
    end

endmodule

// File: rtl/fib_seq_ctrl.sv
// Fills register-file entries 2..n_max with the Fibonacci recurrence of entries 0 and 1.
// Latency: 3 cycles per written element, done one cycle after the last write.
// Backpressure: none; start is ignored while busy. Build option FIB_SAT_EN saturates on carry-out.
module fib_seq_ctrl
    import fib_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] n_max,
    output logic [ADDR_W-1:0] r1_addr,
    output logic [ADDR_W-1:0] r2_addr,
    input  logic [DATA_W-1:0] r1_dout,
    input  logic [DATA_W-1:0] r2_dout,
    output logic [ADDR_W-1:0] r3_addr,
    output logic [DATA_W-1:0] r3_din,
    output logic              r3_wr,
    output logic              busy,
    output logic              done,
    output logic              ovf
);

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W-1:0] idx;
    logic [ADDR_W-1:0] n_lat;
    logic [DATA_W:0]   sum_q;
    logic [DATA_W-1:0] res_q;
    logic [DATA_W:0]   add_sum;
    logic [DATA_W-1:0] add_res;
    logic              more;

    // Another element remains after the current one; also guards idx against wrapping past 31.
    assign more = (idx < n_lat);

    fib_add u_add (
        .a       (r1_dout),
        .b       (r2_dout),
        .sum     (add_sum),
        .sum_reg (sum_q),
        .result  (add_res)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and output decode; outputs are pure functions of state so reset clears them at once.
    always_comb begin
        state_nxt = state;
        r1_addr   = '0;
        r2_addr   = '0;
        r3_addr   = '0;
        r3_din    = '0;
        r3_wr     = 1'b0;
        done      = 1'b0;
        busy      = (state != IDLE);
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = (n_max >= FIRST_IDX) ? READ : DONE;
                end
            end
            READ: begin
                r1_addr   = idx - ADDR_W'(2);
                r2_addr   = idx - ADDR_W'(1);
                state_nxt = EXEC;
            end
            EXEC: begin
                state_nxt = WRITE;
            end
            WRITE: begin
                r3_addr   = idx;
                r3_din    = res_q;
                r3_wr     = 1'b1;
                state_nxt = more ? READ : DONE;
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Datapath: latch the run length, capture the sum, form the result, advance the index.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx   <= '0;
            n_lat <= '0;
            sum_q <= '0;
            res_q <= '0;
            ovf   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        n_lat <= n_max;
                        idx   <= FIRST_IDX;
                        ovf   <= 1'b0;
                    end
                end
                READ: begin
                    sum_q <= add_sum;
                end
                EXEC: begin
                    ovf   <= ovf | sum_q[DATA_W];
                    res_q <= add_res;
                end
                WRITE: begin
                    if (more) begin
                        idx <= idx + ADDR_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fib_seq_ctrl.sv
// Self-checking bench for fib_seq_ctrl against a register-file model and a Fibonacci reference.
// Latency: n/a.
// Backpressure: n/a.
module tb_fib_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [4:0]  n_max = '0;
    logic [4:0]  r1_addr, r2_addr, r3_addr;
    logic [31:0] r1_dout, r2_dout, r3_din;
    logic        r3_wr, busy, done, ovf;

`ifdef FIB_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic [31:0] mem [32];

    int total = 0;
    int bad = 0;

    int          rel;
    int          busy_cnt;
    int          done_rel;
    logic        ovf_done;
    int          zero_bad;
    int          wa[$];
    logic [31:0] wd[$];
    int          wc[$];

    always #5 clk = ~clk;

    assign r1_dout = mem[r1_addr];
    assign r2_dout = mem[r2_addr];

    fib_seq_ctrl dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .n_max   (n_max),
        .r1_addr (r1_addr),
        .r2_addr (r2_addr),
        .r1_dout (r1_dout),
        .r2_dout (r2_dout),
        .r3_addr (r3_addr),
        .r3_din  (r3_din),
        .r3_wr   (r3_wr),
        .busy    (busy),
        .done    (done),
        .ovf     (ovf)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // One cycle: sample on the falling edge, record writes and apply them to the register model.
    task automatic tick();
        @(negedge clk);
        rel++;
        if (busy) busy_cnt++;
        if (done && done_rel < 0) begin
            done_rel = rel;
            ovf_done = ovf;
        end
        if (r3_wr) begin
            wa.push_back(int'(r3_addr));
            wd.push_back(r3_din);
            wc.push_back(rel);
            if (r3_addr != 0) mem[r3_addr] = r3_din;
        end else if (r3_addr != 0 || r3_din != 0) begin
            zero_bad++;
        end
    endtask

    task automatic preload(input logic [31:0] p0, input logic [31:0] p1);
        mem[0] = p0;
        mem[1] = p1;
        for (int i = 2; i < 32; i++) mem[i] = '0;
    endtask

    task automatic clear_log();
        wa.delete();
        wd.delete();
        wc.delete();
        rel      = 0;
        busy_cnt = 0;
        done_rel = -1;
        ovf_done = 1'bx;
        zero_bad = 0;
    endtask

    task automatic run_case(input int n, input logic [31:0] p0, input logic [31:0] p1,
                            input bit pulse, input bit scramble, input bit hold);
        logic [31:0] e [32];
        logic [32:0] s;
        logic        ovf_e;
        int          exp_done;
        int          nw;
        int          lim;
        preload(p0, p1);
        // Reference: each entry is the sum of the two before it; a carry flags overflow.
        for (int i = 0; i < 32; i++) e[i] = mem[i];
        ovf_e = 1'b0;
        for (int i = 2; i <= n; i++) begin
            s = {1'b0, e[i-2]} + {1'b0, e[i-1]};
            if (s[32]) ovf_e = 1'b1;
            e[i] = (SAT && s[32]) ? 32'hFFFF_FFFF : s[31:0];
        end
        nw       = (n >= 2) ? n - 1 : 0;
        exp_done = (n >= 2) ? 3 * (n - 1) + 1 : 1;

        clear_log();
        n_max = 5'(n);
        start = 1'b1;
        while (done_rel < 0 && rel < 200) begin
            tick();
            if (!hold && rel == 1) start = 1'b0;
            if (pulse && rel == 5) start = 1'b1;
            if (pulse && rel == 6) start = 1'b0;
            if (scramble) n_max = 5'($urandom);
        end
        check($sformatf("done_cyc n=%0d", n), 64'(done_rel), 64'(exp_done));
        check($sformatf("busy_cyc n=%0d", n), 64'(busy_cnt), 64'(exp_done));
        check($sformatf("ovf n=%0d", n), 64'(ovf_done), 64'(ovf_e));
        check($sformatf("nwr n=%0d", n), 64'(wa.size()), 64'(nw));
        check($sformatf("addr0 n=%0d", n), 64'(zero_bad), 64'd0);
        lim = (wa.size() < nw) ? wa.size() : nw;
        for (int k = 0; k < lim; k++) begin
            check($sformatf("waddr n=%0d k=%0d", n, k), 64'(wa[k]), 64'(k + 2));
            check($sformatf("wdata n=%0d k=%0d", n, k), 64'(wd[k]), 64'(e[k+2]));
            check($sformatf("wcyc n=%0d k=%0d", n, k), 64'(wc[k]), 64'(3 * (k + 1)));
        end
        if (hold) begin
            // Start still high: one IDLE cycle, then the next run is under way.
            tick();
            check("hold_idle", 64'(busy), 64'd0);
            clear_log();
            tick();
            check("hold_rerun", 64'(busy), 64'd1);
            start = 1'b0;
            while (done_rel < 0 && rel < 200) tick();
            check("hold_done", 64'(done_rel), 64'(exp_done));
        end
        tick();
        check($sformatf("idle_after n=%0d", n), 64'(busy), 64'd0);
    endtask

    task automatic mid_reset();
        bit found;
        int hi;
        preload(32'd1, 32'd1);
        clear_log();
        found = 1'b0;
        n_max = 5'd10;
        start = 1'b1;
        while (!found && rel < 60) begin
            tick();
            if (rel == 1) start = 1'b0;
            if (r3_wr && r3_addr == 5'd4) found = 1'b1;
        end
        check("rst_reach_w4", 64'(found), 64'd1);
        rst_n = 1'b0;
        #1;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_wr", 64'(r3_wr), 64'd0);
        check("rst_waddr", 64'(r3_addr), 64'd0);
        check("rst_wdata", 64'(r3_din), 64'd0);
        check("rst_done_ovf", 64'({done, ovf}), 64'd0);
        check("rst_raddr", 64'({r1_addr, r2_addr}), 64'd0);
        repeat (3) tick();
        rst_n = 1'b1;
        hi = 0;
        foreach (wa[k]) if (wa[k] >= 5) hi++;
        check("rst_no_hi_write", 64'(hi), 64'd0);
        check("rst_nwr", 64'(wa.size()), 64'd3);
    endtask

    initial begin
        int n;
        bit pl;
        preload(32'd1, 32'd1);
        #1;
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_done", 64'(done), 64'd0);
        check("reset_ovf", 64'(ovf), 64'd0);
        check("reset_wr", 64'(r3_wr), 64'd0);
        check("reset_addrs", 64'({r1_addr, r2_addr, r3_addr}), 64'd0);
        check("reset_wdata", 64'(r3_din), 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        run_case(10, 32'd1, 32'd1, 1'b0, 1'b0, 1'b0);
        run_case(1, 32'd1, 32'd1, 1'b0, 1'b0, 1'b0);
        run_case(0, 32'd1, 32'd1, 1'b0, 1'b0, 1'b0);
        run_case(2, 32'hFFFF_FFF0, 32'h20, 1'b0, 1'b0, 1'b0);
        run_case(10, 32'd1, 32'd1, 1'b1, 1'b1, 1'b0);
        mid_reset();
        run_case(10, 32'd1, 32'd1, 1'b0, 1'b0, 1'b0);
        run_case(31, 32'd1, 32'd1, 1'b0, 1'b0, 1'b0);
        run_case(4, 32'd1, 32'd1, 1'b0, 1'b0, 1'b1);
        for (int r = 0; r < 8; r++) begin
            n  = $urandom_range(0, 31);
            pl = (n >= 3) ? 1'($urandom) : 1'b0;
            run_case(n, $urandom, $urandom, pl, 1'b1, 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fib_seq_ctrl.md
FIB_SEQ_CTRL -- requirements
Module: fib_seq_ctrl

Interface
REQ-001 SHALL have clk, input, 1, system clock; all state changes on rising edge.
REQ-002 SHALL have rst_n, input, 1, reset, asynchronous, active-low.
REQ-003 SHALL have start, input, 1, level sampled in IDLE; begins a run.
REQ-004 SHALL have n_max, input, 5, highest register index to fill; latched on accepted start.
REQ-005 SHALL have r1_addr, output, 5, register-file read port 1 address.
REQ-006 SHALL have r2_addr, output, 5, register-file read port 2 address.
REQ-007 SHALL have r1_dout, input, 32, read data for r1_addr, combinational same cycle.
REQ-008 SHALL have r2_dout, input, 32, read data for r2_addr, combinational same cycle.
REQ-009 SHALL have r3_addr, output, 5, write address; 0 means no write.
REQ-010 SHALL have r3_din, output, 32, write data.
REQ-011 SHALL have r3_wr, output, 1, write strobe, one cycle per element.
REQ-012 SHALL have busy, output, 1, high in any state other than IDLE.
REQ-013 SHALL have done, output, 1, one-cycle pulse at run end.
REQ-014 SHALL have ovf, output, 1, sticky carry-out flag for current run.

Function
REQ-015 States SHALL be IDLE, READ, EXEC, WRITE, DONE.
REQ-016 IDLE: start=1 latches n_max, sets idx=2, clears ovf; goes READ if n_max>=2, else DONE with zero writes.
REQ-017 READ: r1_addr=idx-2, r2_addr=idx-1; sum register captures 33-bit r1_dout+r2_dout at cycle end; next EXEC.
REQ-018 EXEC: carry bit 32 ORed into ovf; result formed per REQ-027/028; next WRITE.
REQ-019 WRITE: r3_addr=idx, r3_din=result, r3_wr=1 for exactly this cycle; idx increments; next READ if idx<latched n_max, else DONE.
REQ-020 DONE: done=1 for one cycle; next IDLE.
REQ-021 Outside WRITE, r3_wr=0, r3_addr=0, r3_din=0; r1_addr/r2_addr=0 outside READ.
REQ-022 Latency: N=n_max>=2 gives N-1 writes, 3 cycles each, done in cycle 3(N-1)+1 after start accepted; N<2 gives done 1 cycle after start.
REQ-023 start while busy SHALL be ignored; n_max changes while busy SHALL have no effect.
REQ-024 start held high through DONE SHALL launch a new run from IDLE on the following cycle.
REQ-025 idx SHALL never exceed 31; n_max=31 writes indices 2..31, no wrap.

Reset
REQ-026 Asynchronous assertion SHALL force IDLE, idx=0, sum=0, ovf=0, done=0, busy=0, r3_wr=0, all addresses and r3_din=0; mid-run reset abandons run, no further writes.

Configuration
REQ-027 With FIB_SAT_EN defined, a carry-out SHALL make result 32'hFFFF_FFFF.
REQ-028 Without FIB_SAT_EN, result SHALL be low 32 bits of sum (wrap); ovf behaves identically in both builds.

Structure
REQ-029 Package fib_pkg SHALL hold the state enum, data width 32, address width 5, first index constant 2.
REQ-030 Sub-module fib_add SHALL implement 33-bit add plus optional saturation; FSM stays in fib_seq_ctrl.

Verification
REQ-031 Bench register model reset to reg0=reg1=1, others 0; start, n_max=10 -> writes reg2..reg10 = 2,3,5,8,13,21,34,55,89; done cycle 28; ovf=0.
REQ-032 n_max=1 -> zero writes, done one cycle after start, busy high one cycle.
REQ-033 Preload reg0=32'hFFFF_FFF0, reg1=32'h20, n_max=2 -> ovf=1; reg2=32'h10 default build, 32'hFFFF_FFFF with FIB_SAT_EN.
REQ-034 Pulse start again during run at cycle 5 -> ignored, write sequence and done timing unchanged.
REQ-035 Assert rst_n low during WRITE of idx=4, n_max=10 -> outputs zero immediately, no write to reg5+, next start restarts at idx=2.
REQ-036 n_max=31 -> exactly 30 writes, last r3_addr=31, done cycle 91, r3_addr=0 whenever r3_wr=0.
